err_demod_gen: RTL

- Upstream stage of the FOG closed loop. Generates the square-wave bias modulation phase and demodulates the ADC stream against it.
- Once per modulation period, emits a signed error word plus a one-cycle strobe. These drive the feedback step generator's i_err and i_trig.
- Sits between the ADC capture register and the feedback step generator.

---
 rtl/err_demod_gen.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/err_demod_gen.sv
`default_nettype none
// ============================================================================
//  Module   : err_demod_gen
//  Purpose  : Square-wave bias modulation generator and synchronous
//             demodulator. Integrates the ADC stream separately over the
//             high and low modulation halves, then once per period emits
//             a scaled, offset-corrected, saturated error word with a
//             one-cycle strobe for the feedback step generator.
//  Revision : 1.0  initial release
// ============================================================================
module err_demod_gen #(
    parameter int ADC_W = 14,
    parameter int ACC_W = 40
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic        [31:0]      i_half_period,
    input  logic        [31:0]      i_wait_cnt,
    input  logic        [4:0]       i_avg_sel,
    input  logic        [31:0]      i_err_offset,
    input  logic                    i_polarity,
    output logic                    o_mod,
    output logic signed [31:0]      o_err,
    output logic                    o_trig,
    output logic                    o_sat
);

    // Saturation bounds of the 32-bit signed error word
    localparam logic [31:0] c_err_max  = 32'h7fff_ffff;
    localparam logic [31:0] c_err_min  = 32'h8000_0000;
    // Shortest allowed modulation half period
    localparam logic [31:0] c_min_half = 32'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_start;
    logic   w_run;

    // Period counter, phase and integrators
    logic        [31:0]      r_cnt;
    logic                    r_mod;
    logic signed [ACC_W-1:0] r_acc_hi;
    logic signed [ACC_W-1:0] r_acc_lo;

    // Configuration captured at each period start
    logic        [31:0]      r_half;
    logic        [31:0]      r_wait;
    logic        [4:0]       r_shift;
    logic        [31:0]      r_offset;
    logic                    r_pol;

    // Output registers
    logic        [31:0]      r_err;
    logic                    r_trig;
    logic                    r_sat;

    // Datapath wires
    logic        [31:0]      w_half_clamp;
    logic                    w_half_end;
    logic                    w_take;
    logic signed [ACC_W-1:0] w_adc_ext;
    logic signed [ACC_W-1:0] w_acc_lo_fin;
    logic signed [ACC_W-1:0] w_diff_raw;
    logic signed [ACC_W-1:0] w_diff;
    logic signed [ACC_W:0]   w_res;
    logic        [ACC_W-31:0] w_res_top;
    logic                    w_sat_clip;
    logic        [31:0]      w_clip;
    logic                    w_sat_neg;
    logic        [31:0]      w_final;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: idle until enabled, run until enable drops
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_en) begin
                    w_run = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Half-period clamp, half-end detection and sample gating
    assign w_half_clamp = (i_half_period < c_min_half) ? c_min_half : i_half_period;
    assign w_half_end   = (r_cnt == (r_half - 32'd1));
    assign w_take       = (r_cnt >= r_wait);
    assign w_adc_ext    = {{(ACC_W-ADC_W){i_adc[ADC_W-1]}}, i_adc};

    // The final low-half sample is folded in combinationally so the
    // result can be registered on the same edge that closes the period.
    assign w_acc_lo_fin = w_take ? (r_acc_lo + w_adc_ext) : r_acc_lo;
    assign w_diff_raw   = r_acc_hi - w_acc_lo_fin;
    assign w_diff       = w_diff_raw >>> r_shift;

    // One extra bit of headroom so the offset subtraction cannot wrap
    assign w_res        = {w_diff[ACC_W-1], w_diff}
                        - {{(ACC_W+1-32){r_offset[31]}}, r_offset};

    // Out of 32-bit range when the bits above bit 30 are not a pure sign extension
    assign w_res_top    = w_res[ACC_W:31];
    assign w_sat_clip   = !((&w_res_top) || !(|w_res_top));
    assign w_clip       = w_sat_clip ? (w_res[ACC_W] ? c_err_min : c_err_max)
                                     : w_res[31:0];

    // Negating the most negative value has no representation; clip it
    assign w_sat_neg    = r_pol && (w_clip == c_err_min);
    assign w_final      = !r_pol   ? w_clip :
                          w_sat_neg ? c_err_max :
                                      (~w_clip + 32'd1);

    // Counter, phase, integrators, configuration latch and result register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_mod    <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_half   <= c_min_half;
            r_wait   <= '0;
            r_shift  <= '0;
            r_offset <= '0;
            r_pol    <= 1'b0;
            r_err    <= '0;
            r_trig   <= 1'b0;
            r_sat    <= 1'b0;
        end else if (!i_en) begin
            // Idle: hold everything cleared; any partial period is discarded
            r_cnt    <= '0;
            r_mod    <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_err    <= '0;
            r_trig   <= 1'b0;
            r_sat    <= 1'b0;
        end else if (w_start) begin
            // First enabled cycle opens a high half with fresh configuration
            r_cnt    <= '0;
            r_mod    <= 1'b1;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_trig   <= 1'b0;
            r_half   <= w_half_clamp;
            r_wait   <= i_wait_cnt;
            r_shift  <= i_avg_sel;
            r_offset <= i_err_offset;
            r_pol    <= i_polarity;
        end else if (w_run) begin
            r_trig <= 1'b0;
            if (w_half_end) begin
                r_cnt <= '0;
                r_mod <= ~r_mod;
                if (r_mod) begin
                    // Last high-half sample
                    if (w_take) begin
                        r_acc_hi <= r_acc_hi + w_adc_ext;
                    end
                end else begin
                    // Period close: publish result, clear integrators, relatch
                    r_err    <= w_final;
                    r_trig   <= 1'b1;
                    r_sat    <= r_sat | w_sat_clip | w_sat_neg;
                    r_acc_hi <= '0;
                    r_acc_lo <= '0;
                    r_half   <= w_half_clamp;
                    r_wait   <= i_wait_cnt;
                    r_shift  <= i_avg_sel;
                    r_offset <= i_err_offset;
                    r_pol    <= i_polarity;
                end
            end else begin
                r_cnt <= r_cnt + 32'd1;
                if (w_take) begin
                    if (r_mod) begin
                        r_acc_hi <= r_acc_hi + w_adc_ext;
                    end else begin
                        r_acc_lo <= r_acc_lo + w_adc_ext;
                    end
                end
            end
        end
    end

    assign o_mod  = r_mod;
    assign o_err  = r_err;
    assign o_trig = r_trig;
    assign o_sat  = r_sat;

endmodule
`default_nettype wire
